dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
- Sequences every data-SRAM access and arbitrates the SRAM between two requesters: the pipeline MEM stage (port P) and the debug/program loader (port D).
- Checks alignment and generates byte write strobes and replicated write data for sb/sh/sw.
- Stalls the pipeline until the access completes.
- Returns the raw 32-bit SRAM word; load byte/half extraction stays in the MEM stage.

Parameters:
- SRAM_LAT, 1: cycles from data_sram_en to valid data_sram_rdata; legal range 1..4.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- p_req  in  1  MEM-stage request; held stable while p_stall=1
- p_wr  in  1  1=store, 0=load
- p_size  in  2  00 byte, 01 half, 10 word; 11 treated as word
- p_addr  in  32  byte address
- p_wdata  in  32  store data, right-aligned
- p_stall  out  1  pipeline freeze
- p_done  out  1  one-cycle completion pulse
- p_err  out  1  misaligned-address pulse, coincident with p_done
- p_rdata  out  32  registered raw SRAM word
- d_req, d_wr, d_size, d_addr, d_wdata  in  1/1/2/32/32  loader request, same meaning as P
- d_done  out  1  loader completion pulse
- d_err  out  1  loader misaligned pulse, coincident with d_done
- d_rdata  out  32  registered raw SRAM word
- data_sram_en  out  1  SRAM enable
- data_sram_wen  out  4  byte write strobes
- data_sram_addr  out  32  word-aligned address {addr[31:2],2'b00}
- data_sram_wdata  out  32  replicated store data
- data_sram_rdata  in  32  SRAM read data

Behaviour:
- Reset (async, reset=0): state IDLE. All outputs 0, including data_sram_en/wen and rdata registers. last_grant=D, so P wins the first tie. An access in flight is abandoned; the strobe drops immediately.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - If p_req or d_req is high: latch the winner's wr/size/addr/wdata and owner.
  - Misaligned request (half with addr[0]=1, or word with addr[1:0]!=0) goes to RESP with err flag set and no SRAM access.
  - Otherwise go to ACCESS.
- Arbitration:
  - Only one requester high: that one wins.
  - Both high: the requester not granted last time wins.
  - last_grant updates on every grant. No preemption.
- ACCESS (exactly 1 cycle): data_sram_en=1, with addr/wen/wdata driven from the latched request. Then go to WAIT, counter=SRAM_LAT-1.
- WAIT:
  - en=0, wen=0.
  - Counter 0: capture data_sram_rdata into the owner's rdata register (loads only; stores leave it unchanged), then go to RESP.
  - Otherwise decrement the counter.
- RESP (1 cycle): owner's done=1, err=latched flag; then go to IDLE. A new request may be granted in the next IDLE cycle, never in RESP.
- Write strobes (stores only; loads wen=0000):
  - byte: wen=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}.
  - half: addr[1]=0 gives wen 0011, addr[1]=1 gives 1100; wdata={2{wdata[15:0]}}.
  - word: wen 1111, wdata unchanged.
- p_stall (combinational) = p_req & ~p_done. It is high from the first cycle p_req is seen, including while D owns the SRAM. It is low in the P RESP cycle so the pipeline advances on that edge.
- Latency, aligned access with no contention: request at cycle 0 → en at cycle 1 → done at cycle 2+SRAM_LAT. With SRAM_LAT=1 that is done at cycle 3 and stall high for cycles 0–2.
- Latency, misaligned: done+err at cycle 1; the SRAM is never enabled.
- Requester behaviour during ownership: a requester dropping its req while it owns the access is ignored; the access completes and still pulses done. Requests changing while not granted are sampled only in IDLE.
- data_sram_addr/wdata hold their last value when en=0 (don't-care for the SRAM).

Test Plan:
- Load, SRAM_LAT=1: P load word addr 0x100, SRAM returns 0xDEADBEEF.
  → en at cycle 1 with addr 0x100, wen 0000.
  → p_done at cycle 3, p_rdata=0xDEADBEEF.
  → p_stall high for cycles 0–2, low at cycle 3.
- Store strobes: P sb addr 0x103 wdata 0x5A → wen 1000, wdata 0x5A5A5A5A. P sh addr 0x102 wdata 0x1234 → wen 1100, wdata 0x12341234. P sw → wen 1111.
- Misaligned: P lh addr 0x101 → p_done=p_err=1 at cycle 1; data_sram_en never asserted. Repeat with lw addr 0x102, same result.
- Contention: p_req and d_req both high from reset, held.
  → P granted first, D second, then P.
  → p_stall stays high during D's access.
  → d_done and p_done never pulse in the same cycle.
- SRAM_LAT=3: load completes at cycle 5. rdata changed at cycles 2 and 3 and valid only at cycle 4 → captured value is the cycle-4 data.
- Reset in WAIT: assert reset during a D store's WAIT cycle.
  → all outputs 0 immediately.
  → after release, a pending P request is granted first (last_grant=D).

Source files
------------

// File: rtl/dmem_access_ctrl_if.sv
// Bus bundle for the data-memory access controller: MEM-stage port (p_*),
// loader port (d_*) and the single-port data SRAM (data_sram_*).
//
// Port summary
//   p_req/p_wr/p_size/p_addr/p_wdata  MEM-stage request (size 00 b, 01 h, 1x w)
//   p_stall/p_done/p_err/p_rdata      MEM-stage freeze, completion, error, word
//   d_req/d_wr/d_size/d_addr/d_wdata  loader request, same encoding as P
//   d_done/d_err/d_rdata              loader completion, error, word
//   data_sram_en/wen/addr/wdata       SRAM enable, byte strobes, word addr, data
//   data_sram_rdata                   SRAM read word
//
// Modports
//   master : requesters and the SRAM (drive requests and read data)
//   slave  : the controller
interface dmem_access_ctrl_if;
    logic        p_req;
    logic        p_wr;
    logic [1:0]  p_size;
    logic [31:0] p_addr;
    logic [31:0] p_wdata;
    logic        p_stall;
    logic        p_done;
    logic        p_err;
    logic [31:0] p_rdata;

    logic        d_req;
    logic        d_wr;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_done;
    logic        d_err;
    logic [31:0] d_rdata;

    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;

    modport master (
        output p_req, p_wr, p_size, p_addr, p_wdata,
        input  p_stall, p_done, p_err, p_rdata,
        output d_req, d_wr, d_size, d_addr, d_wdata,
        input  d_done, d_err, d_rdata,
        input  data_sram_en, data_sram_wen,
        input  data_sram_addr, data_sram_wdata,
        output data_sram_rdata
    );

    modport slave (
        input  p_req, p_wr, p_size, p_addr, p_wdata,
        output p_stall, p_done, p_err, p_rdata,
        input  d_req, d_wr, d_size, d_addr, d_wdata,
        output d_done, d_err, d_rdata,
        output data_sram_en, data_sram_wen,
        output data_sram_addr, data_sram_wdata,
        input  data_sram_rdata
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Data-SRAM access sequencer and two-way arbiter (MEM stage P, loader D).
// Checks alignment, builds byte strobes / replicated store data, stalls P.
//
// Ports
//   clk    : clock
//   reset  : asynchronous, active-low reset
//   bus    : dmem_access_ctrl_if.slave (P request/response, D request/
//            response, data SRAM)
//
// Parameter
//   SRAM_LAT : cycles from data_sram_en to valid data_sram_rdata (1..4)
//
// Sequence per access: IDLE (grant) -> ACCESS (en=1, 1 cycle) ->
// WAIT (SRAM_LAT cycles, capture on the last) -> RESP (done pulse) -> IDLE.
// Misaligned requests skip straight from IDLE to RESP with the error flag.
module dmem_access_ctrl #(
    parameter int SRAM_LAT = 1
) (
    input logic               clk,
    input logic               reset,
    dmem_access_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } state_t;

    localparam logic [1:0] LAT_M1 = 2'(SRAM_LAT - 1);

    state_t      state;
    logic        last_d;
    logic        own_d;
    logic        wr_q;
    logic [1:0]  cnt;

    logic        p_done_q;
    logic        p_err_q;
    logic [31:0] p_rdata_q;
    logic        d_done_q;
    logic        d_err_q;
    logic [31:0] d_rdata_q;

    logic        en_q;
    logic [3:0]  wen_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic        grant_d;
    logic        sel_wr;
    logic [1:0]  sel_size;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        mis;
    logic [3:0]  wen_n;
    logic [31:0] wdata_n;

    // When both request, D only wins if P was granted last.
    always_comb begin
        grant_d   = bus.d_req & ~(bus.p_req & last_d);
        sel_wr    = grant_d ? bus.d_wr    : bus.p_wr;
        sel_size  = grant_d ? bus.d_size  : bus.p_size;
        sel_addr  = grant_d ? bus.d_addr  : bus.p_addr;
        sel_wdata = grant_d ? bus.d_wdata : bus.p_wdata;
    end

    always_comb begin
        mis = 1'b0;
        unique case (sel_size)
            2'b00:   mis = 1'b0;
            2'b01:   mis = sel_addr[0];
            default: mis = |sel_addr[1:0];
        endcase
    end

    // Strobes and lane-replicated data for the winner's request.
    always_comb begin
        wen_n   = 4'b0000;
        wdata_n = sel_wdata;
        unique case (sel_size)
            2'b00: begin
                wen_n   = 4'b0001 << sel_addr[1:0];
                wdata_n = {4{sel_wdata[7:0]}};
            end
            2'b01: begin
                wen_n   = sel_addr[1] ? 4'b1100 : 4'b0011;
                wdata_n = {2{sel_wdata[15:0]}};
            end
            default: begin
                wen_n   = 4'b1111;
                wdata_n = sel_wdata;
            end
        endcase
        if (!sel_wr) begin
            wen_n = 4'b0000;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            last_d    <= 1'b1;
            own_d     <= 1'b0;
            wr_q      <= 1'b0;
            cnt       <= 2'd0;
            p_done_q  <= 1'b0;
            p_err_q   <= 1'b0;
            p_rdata_q <= 32'd0;
            d_done_q  <= 1'b0;
            d_err_q   <= 1'b0;
            d_rdata_q <= 32'd0;
            en_q      <= 1'b0;
            wen_q     <= 4'b0000;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
        end else begin
            // Pulses and the SRAM enable last exactly one cycle.
            p_done_q <= 1'b0;
            p_err_q  <= 1'b0;
            d_done_q <= 1'b0;
            d_err_q  <= 1'b0;
            en_q     <= 1'b0;
            wen_q    <= 4'b0000;

            unique case (state)
                IDLE: begin
                    if (bus.p_req | bus.d_req) begin
                        own_d  <= grant_d;
                        last_d <= grant_d;
                        wr_q   <= sel_wr;
                        if (mis) begin
                            state    <= RESP;
                            p_done_q <= ~grant_d;
                            p_err_q  <= ~grant_d;
                            d_done_q <= grant_d;
                            d_err_q  <= grant_d;
                        end else begin
                            state   <= ACCESS;
                            en_q    <= 1'b1;
                            wen_q   <= wen_n;
                            addr_q  <= {sel_addr[31:2], 2'b00};
                            wdata_q <= wdata_n;
                        end
                    end
                end

                ACCESS: begin
                    state <= WAIT;
                    cnt   <= LAT_M1;
                end

                WAIT: begin
                    if (cnt == 2'd0) begin
                        state <= RESP;
                        if (!wr_q) begin
                            if (own_d) begin
                                d_rdata_q <= bus.data_sram_rdata;
                            end else begin
                                p_rdata_q <= bus.data_sram_rdata;
                            end
                        end
                        p_done_q <= ~own_d;
                        d_done_q <= own_d;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end

                RESP: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.p_stall         = bus.p_req & ~p_done_q;
    assign bus.p_done          = p_done_q;
    assign bus.p_err           = p_err_q;
    assign bus.p_rdata         = p_rdata_q;
    assign bus.d_done          = d_done_q;
    assign bus.d_err           = d_err_q;
    assign bus.d_rdata         = d_rdata_q;
    assign bus.data_sram_en    = en_q;
    assign bus.data_sram_wen   = wen_q;
    assign bus.data_sram_addr  = addr_q;
    assign bus.data_sram_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: SRAM_LAT=1 and SRAM_LAT=3 instances.
// Inputs change 1 time unit after posedge; outputs are sampled 2 units later.
module tb_dmem_access_ctrl;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    dmem_access_ctrl_if b1 ();
    dmem_access_ctrl_if b3 ();

    dmem_access_ctrl #(.SRAM_LAT(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (b1.slave)
    );

    dmem_access_ctrl #(.SRAM_LAT(3)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (b3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic next_cyc;
        @(posedge clk);
        #1;
    endtask

    // One P access on the SRAM_LAT=1 instance; cycle 0 = request cycle.
    task automatic p_access(
        input  logic        wr,
        input  logic [1:0]  size,
        input  logic [31:0] addr,
        input  logic [31:0] wdata,
        input  logic [31:0] rdata,
        output int          en_cyc,
        output int          done_cyc,
        output logic [3:0]  wen,
        output logic [31:0] sw,
        output logic [31:0] sa,
        output logic        err,
        output logic [7:0]  stall_v
    );
        en_cyc   = -1;
        done_cyc = -1;
        wen      = 4'h0;
        sw       = 32'h0;
        sa       = 32'h0;
        err      = 1'b0;
        stall_v  = 8'h00;
        next_cyc;
        b1.p_req           = 1'b1;
        b1.p_wr            = wr;
        b1.p_size          = size;
        b1.p_addr          = addr;
        b1.p_wdata         = wdata;
        b1.data_sram_rdata = rdata;
        for (int c = 0; c < 16; c++) begin
            if (c > 0) next_cyc;
            #2;
            if (c < 8) stall_v[c] = b1.p_stall;
            if (b1.data_sram_en) begin
                en_cyc = c;
                wen    = b1.data_sram_wen;
                sw     = b1.data_sram_wdata;
                sa     = b1.data_sram_addr;
            end
            if (b1.p_done) begin
                done_cyc = c;
                err      = b1.p_err;
                break;
            end
        end
        next_cyc;
        b1.p_req = 1'b0;
    endtask

    int          en_cyc;
    int          done_cyc;
    logic [3:0]  wen;
    logic [31:0] sw;
    logic [31:0] sa;
    logic        err;
    logic [7:0]  stall_v;
    logic        order [16];
    int          n_ord;
    int          collide;
    int          stall_low;
    int          l3_en;
    int          l3_done;
    logic [31:0] got_addr;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        {b1.p_req, b1.p_wr, b1.p_size} = '0;
        {b1.d_req, b1.d_wr, b1.d_size} = '0;
        b1.p_addr = '0; b1.p_wdata = '0;
        b1.d_addr = '0; b1.d_wdata = '0;
        b1.data_sram_rdata = '0;
        {b3.p_req, b3.p_wr, b3.p_size} = '0;
        {b3.d_req, b3.d_wr, b3.d_size} = '0;
        b3.p_addr = '0; b3.p_wdata = '0;
        b3.d_addr = '0; b3.d_wdata = '0;
        b3.data_sram_rdata = '0;

        #12;
        chk("rst_en",    32'(b1.data_sram_en),  32'h0);
        chk("rst_wen",   32'(b1.data_sram_wen), 32'h0);
        chk("rst_done",  32'({b1.p_done, b1.d_done, b1.p_err, b1.d_err}), 32'h0);
        chk("rst_rdata", b1.p_rdata | b1.d_rdata, 32'h0);
        next_cyc;
        reset = 1'b1;
        next_cyc;

        // Word load, SRAM_LAT=1
        p_access(1'b0, 2'b10, 32'h100, 32'h0, 32'hDEADBEEF,
                 en_cyc, done_cyc, wen, sw, sa, err, stall_v);
        chk("lw_en_cyc",   32'(en_cyc),   32'd1);
        chk("lw_addr",     sa,            32'h100);
        chk("lw_wen",      32'(wen),      32'h0);
        chk("lw_done_cyc", 32'(done_cyc), 32'd3);
        chk("lw_stall",    32'(stall_v[3:0]), 32'h7);
        chk("lw_err",      32'(err),      32'h0);
        chk("lw_rdata",    b1.p_rdata,    32'hDEADBEEF);

        // Stores
        p_access(1'b1, 2'b00, 32'h103, 32'h0000005A, 32'h11111111,
                 en_cyc, done_cyc, wen, sw, sa, err, stall_v);
        chk("sb3_wen",   32'(wen), 32'h8);
        chk("sb3_wdata", sw,       32'h5A5A5A5A);
        chk("sb3_addr",  sa,       32'h100);
        chk("sb3_done",  32'(done_cyc), 32'd3);
        chk("sb3_keep_rdata", b1.p_rdata, 32'hDEADBEEF);

        p_access(1'b1, 2'b00, 32'h101, 32'hFFFFFF3C, 32'h0,
                 en_cyc, done_cyc, wen, sw, sa, err, stall_v);
        chk("sb1_wen",   32'(wen), 32'h2);
        chk("sb1_wdata", sw,       32'h3C3C3C3C);

        p_access(1'b1, 2'b01, 32'h102, 32'h00001234, 32'h0,
                 en_cyc, done_cyc, wen, sw, sa, err, stall_v);
        chk("sh2_wen",   32'(wen), 32'hC);
        chk("sh2_wdata", sw,       32'h12341234);

        p_access(1'b1, 2'b01, 32'h100, 32'hABCD5678, 32'h0,
                 en_cyc, done_cyc, wen, sw, sa, err, stall_v);
        chk("sh0_wen",   32'(wen), 32'h3);
        chk("sh0_wdata", sw,       32'h56785678);

        p_access(1'b1, 2'b10, 32'h104, 32'h89ABCDEF, 32'h0,
                 en_cyc, done_cyc, wen, sw, sa, err, stall_v);
        chk("sw_wen",   32'(wen), 32'hF);
        chk("sw_wdata", sw,       32'h89ABCDEF);
        chk("sw_addr",  sa,       32'h104);

        p_access(1'b1, 2'b11, 32'h108, 32'h01020304, 32'h0,
                 en_cyc, done_cyc, wen, sw, sa, err, stall_v);
        chk("sz3_wen",   32'(wen), 32'hF);
        chk("sz3_wdata", sw,       32'h01020304);

        // Misaligned
        p_access(1'b0, 2'b01, 32'h101, 32'h0, 32'h0,
                 en_cyc, done_cyc, wen, sw, sa, err, stall_v);
        chk("lh_mis_done", 32'(done_cyc), 32'd1);
        chk("lh_mis_err",  32'(err),      32'h1);
        chk("lh_mis_en",   32'(en_cyc),   32'hFFFFFFFF);

        p_access(1'b0, 2'b10, 32'h102, 32'h0, 32'h0,
                 en_cyc, done_cyc, wen, sw, sa, err, stall_v);
        chk("lw_mis_done", 32'(done_cyc), 32'd1);
        chk("lw_mis_err",  32'(err),      32'h1);
        chk("lw_mis_en",   32'(en_cyc),   32'hFFFFFFFF);

        // Contention from reset
        next_cyc;
        reset = 1'b0;
        b1.p_req = 1'b1; b1.p_wr = 1'b0; b1.p_size = 2'b10;
        b1.p_addr = 32'h100;
        b1.d_req = 1'b1; b1.d_wr = 1'b0; b1.d_size = 2'b10;
        b1.d_addr = 32'h200;
        b1.data_sram_rdata = 32'h0BADF00D;
        next_cyc;
        reset     = 1'b1;
        n_ord     = 0;
        collide   = 0;
        stall_low = 0;
        for (int c = 0; c < 40; c++) begin
            #2;
            if (b1.p_done && b1.d_done) collide++;
            if (!b1.p_done && !b1.p_stall) stall_low++;
            if (b1.p_done && n_ord < 16) begin
                order[n_ord] = 1'b0;
                n_ord++;
            end
            if (b1.d_done && n_ord < 16) begin
                order[n_ord] = 1'b1;
                n_ord++;
            end
            next_cyc;
        end
        chk("arb_collide", 32'(collide),   32'd0);
        chk("arb_stall",   32'(stall_low), 32'd0);
        chk("arb_count",   32'(n_ord >= 3), 32'd1);
        chk("arb_order",   32'({order[0], order[1], order[2]}), 32'h2);
        chk("arb_d_rdata", b1.d_rdata, 32'h0BADF00D);
        b1.p_req = 1'b0;
        b1.d_req = 1'b0;
        repeat (6) next_cyc;

        // Reset during a D store's WAIT cycle
        b1.d_req = 1'b1; b1.d_wr = 1'b1; b1.d_size = 2'b10;
        b1.d_addr = 32'h200; b1.d_wdata = 32'hA5A5A5A5;
        next_cyc;
        #2;
        chk("rw_pre_en",  32'(b1.data_sram_en),  32'h1);
        chk("rw_pre_wen", 32'(b1.data_sram_wen), 32'hF);
        b1.p_req = 1'b1; b1.p_wr = 1'b0; b1.p_size = 2'b10;
        b1.p_addr = 32'h300;
        next_cyc;
        #2;
        reset = 1'b0;
        #1;
        chk("rw_en",    32'({b1.data_sram_en, b1.data_sram_wen}), 32'h0);
        chk("rw_addr",  b1.data_sram_addr,  32'h0);
        chk("rw_wdata", b1.data_sram_wdata, 32'h0);
        chk("rw_done",  32'({b1.p_done, b1.d_done, b1.p_err, b1.d_err}), 32'h0);
        chk("rw_rdata", b1.p_rdata | b1.d_rdata, 32'h0);
        #2;
        reset    = 1'b1;
        got_addr = 32'hFFFFFFFF;
        for (int c = 0; c < 10; c++) begin
            next_cyc;
            #2;
            if (b1.data_sram_en) begin
                got_addr = b1.data_sram_addr;
                break;
            end
        end
        chk("rw_first_grant", got_addr, 32'h300);
        b1.p_req = 1'b0;
        b1.d_req = 1'b0;
        repeat (8) next_cyc;

        // SRAM_LAT=3 load; only cycle-4 data is valid
        l3_en   = -1;
        l3_done = -1;
        b3.p_req = 1'b1; b3.p_wr = 1'b0; b3.p_size = 2'b10;
        b3.p_addr = 32'h40;
        for (int c = 0; c < 12; c++) begin
            unique case (c)
                2:       b3.data_sram_rdata = 32'h11111111;
                3:       b3.data_sram_rdata = 32'h22222222;
                4:       b3.data_sram_rdata = 32'hCAFEF00D;
                default: b3.data_sram_rdata = 32'h33333333;
            endcase
            #2;
            if (b3.data_sram_en) l3_en = c;
            if (b3.p_done) begin
                l3_done = c;
                break;
            end
            next_cyc;
        end
        chk("l3_en_cyc",   32'(l3_en),   32'd1);
        chk("l3_done_cyc", 32'(l3_done), 32'd5);
        chk("l3_rdata",    b3.p_rdata,   32'hCAFEF00D);
        next_cyc;
        b3.p_req = 1'b0;
        repeat (3) next_cyc;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
